// File: rtl/rv32i_types.sv
// Shared rv32i types for the memory stage.
// Holds the MEM-stage FSM encoding, load/store funct3 encodings,
// the control word and register bundle carried down the pipeline,
// and the datapath widths.
package rv32i_types;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MASK_W     = 4;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned SHIFT_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        HOLD = 2'b10
    } mem_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       load_regfile;
    } ctrl_word_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rs1_rdata;
        logic [XLEN-1:0]       rs2_rdata;
    } reg_bundle_t;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load-data extraction: picks the byte/halfword at the given byte offset
// and sign- or zero-extends it according to the load funct3.
// Ports: funct3_i (load type), shift_i (byte offset), word_i (raw word),
//        ext_o (extended result).
module mem_stage_load_extend
    import rv32i_types::*;
(
    input  load_funct3_t       funct3_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [XLEN-1:0]    word_i,
    output logic [XLEN-1:0]    ext_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = word_i >> {shift_i, 3'b000};
        ext_o   = word_i;
        case (funct3_i)
            lb:      ext_o = {{24{shifted[7]}}, shifted[7:0]};
            lh:      ext_o = {{16{shifted[15]}}, shifted[15:0]};
            lbu:     ext_o = {24'd0, shifted[7:0]};
            lhu:     ext_o = {16'd0, shifted[15:0]};
            default: ext_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rv32i memory-access stage plus MEM/WB pipeline register.
// Issues data-cache requests for loads/stores, stalls the pipeline until the
// cache answers, lane-shifts store data, extends load data and latches the
// writeback payload on every pipeline advance.
// Ports: clk/rst (sync, active-high), load (pipeline advance), EX/MEM payload
// (pc_mem, ctrl_mem, regs_mem, br_en_mem, addresses, masks, trap, store data),
// dmem_* cache request/response, mem_stall to hazard unit, *_wb registered
// payload for writeback and RVFI.
module mem_stage
    import rv32i_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [XLEN-1:0]    pc_mem,
    input  ctrl_word_t         ctrl_mem,
    input  reg_bundle_t        regs_mem,
    input  logic               br_en_mem,
    input  logic [XLEN-1:0]    addr_aligned,
    input  logic [XLEN-1:0]    alu_res_in,
    input  logic [SHIFT_W-1:0] bit_shift,
    input  logic [MASK_W-1:0]  wmask_in,
    input  logic [MASK_W-1:0]  rmask_in,
    input  logic               trap_in,
    input  logic [XLEN-1:0]    write_data_in,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic               dmem_resp,
    output logic [XLEN-1:0]    dmem_address,
    output logic               dmem_read,
    output logic               dmem_write,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic [MASK_W-1:0]  dmem_byte_enable,
    output logic               mem_stall,
    output logic [XLEN-1:0]    pc_wb,
    output ctrl_word_t         ctrl_wb,
    output reg_bundle_t        regs_wb,
    output logic               br_en_wb,
    output logic [XLEN-1:0]    alu_res_wb,
    output logic [XLEN-1:0]    load_data_wb,
    output logic [MASK_W-1:0]  rmask_wb,
    output logic [MASK_W-1:0]  wmask_wb,
    output logic [XLEN-1:0]    mem_addr_wb,
    output logic [XLEN-1:0]    mem_wdata_wb,
    output logic               trap_wb
);

    mem_state_t      state_q;
    logic [XLEN-1:0] rdata_hold_q;
    logic            mem_op;
    logic            is_load;
    logic            req_active;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] load_src;
    logic [XLEN-1:0] load_ext;

    // A trapping instruction never touches memory.
    assign is_load    = (rmask_in != '0) && !trap_in;
    assign mem_op     = ((rmask_in != '0) || (wmask_in != '0)) && !trap_in;
    assign store_data = write_data_in << {bit_shift, 3'b000};

    // Request/stall decode; reset drops any in-flight request at once.
    always_comb begin
        req_active = 1'b0;
        mem_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                req_active = mem_op;
                mem_stall  = mem_op;
            end
            BUSY: begin
                req_active = 1'b1;
                mem_stall  = !dmem_resp;
            end
            default: ;
        endcase
        if (rst) begin
            req_active = 1'b0;
            mem_stall  = 1'b0;
        end
    end

    assign dmem_address     = addr_aligned;
    assign dmem_byte_enable = (wmask_in != '0) ? wmask_in : rmask_in;
    assign dmem_wdata       = store_data;
    assign dmem_read        = (rmask_in != '0) && req_active;
    assign dmem_write       = (wmask_in != '0) && req_active;

    // Response data is only live in BUSY; HOLD replays the captured word.
    assign load_src = (state_q == HOLD) ? rdata_hold_q : dmem_rdata;

    mem_stage_load_extend u_load_extend (
        .funct3_i (load_funct3_t'(ctrl_mem.funct3)),
        .shift_i  (bit_shift),
        .word_i   (load_src),
        .ext_o    (load_ext)
    );

    // FSM plus MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rdata_hold_q <= '0;
            pc_wb        <= '0;
            ctrl_wb      <= '0;
            regs_wb      <= '0;
            br_en_wb     <= 1'b0;
            alu_res_wb   <= '0;
            load_data_wb <= '0;
            rmask_wb     <= '0;
            wmask_wb     <= '0;
            mem_addr_wb  <= '0;
            mem_wdata_wb <= '0;
            trap_wb      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (mem_op) state_q <= BUSY;
                BUSY: begin
                    if (dmem_resp) begin
                        if (load) begin
                            state_q <= IDLE;
                        end else begin
                            rdata_hold_q <= dmem_rdata;
                            state_q      <= HOLD;
                        end
                    end
                end
                HOLD: if (load) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (load) begin
                pc_wb        <= pc_mem;
                ctrl_wb      <= ctrl_mem;
                regs_wb      <= regs_mem;
                br_en_wb     <= br_en_mem;
                alu_res_wb   <= alu_res_in;
                load_data_wb <= is_load ? load_ext : '0;
                rmask_wb     <= rmask_in;
                wmask_wb     <= wmask_in;
                mem_addr_wb  <= addr_aligned;
                mem_wdata_wb <= store_data;
                trap_wb      <= trap_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import rv32i_types::*;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] pc_mem;
    ctrl_word_t  ctrl_mem;
    reg_bundle_t regs_mem;
    logic        br_en_mem;
    logic [31:0] addr_aligned;
    logic [31:0] alu_res_in;
    logic [1:0]  bit_shift;
    logic [3:0]  wmask_in;
    logic [3:0]  rmask_in;
    logic        trap_in;
    logic [31:0] write_data_in;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        mem_stall;
    logic [31:0] pc_wb;
    ctrl_word_t  ctrl_wb;
    reg_bundle_t regs_wb;
    logic        br_en_wb;
    logic [31:0] alu_res_wb;
    logic [31:0] load_data_wb;
    logic [3:0]  rmask_wb;
    logic [3:0]  wmask_wb;
    logic [31:0] mem_addr_wb;
    logic [31:0] mem_wdata_wb;
    logic        trap_wb;

    // Hazard unit: advance unless stalled or deliberately held off.
    logic hold_off;
    assign load = !mem_stall && !hold_off;

    localparam logic [31:0] BUBBLE_PC = 32'hB0B0_0000;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;   // 0 alu, 1 load, 2 store, 3 trap
        logic [2:0]  f3;
        logic [1:0]  shift;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          hold;
    } op_t;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .load             (load),
        .pc_mem           (pc_mem),
        .ctrl_mem         (ctrl_mem),
        .regs_mem         (regs_mem),
        .br_en_mem        (br_en_mem),
        .addr_aligned     (addr_aligned),
        .alu_res_in       (alu_res_in),
        .bit_shift        (bit_shift),
        .wmask_in         (wmask_in),
        .rmask_in         (rmask_in),
        .trap_in          (trap_in),
        .write_data_in    (write_data_in),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_stall        (mem_stall),
        .pc_wb            (pc_wb),
        .ctrl_wb          (ctrl_wb),
        .regs_wb          (regs_wb),
        .br_en_wb         (br_en_wb),
        .alu_res_wb       (alu_res_wb),
        .load_data_wb     (load_data_wb),
        .rmask_wb         (rmask_wb),
        .wmask_wb         (wmask_wb),
        .mem_addr_wb      (mem_addr_wb),
        .mem_wdata_wb     (mem_wdata_wb),
        .trap_wb          (trap_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference load semantics: pick the addressed lane, then extend arithmetically.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] sh,
                                             input logic [31:0] w);
        logic [31:0] v;
        v = w >> {sh, 3'b000};
        case (f3)
            3'b000: begin v = v % 32'd256;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'b001: begin v = v % 32'd65536; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b100: v = v % 32'd256;
            3'b101: v = v % 32'd65536;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] sh);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m << sh;
    endfunction

    task automatic set_bubble();
        pc_mem    = BUBBLE_PC;
        rmask_in  = 4'h0;
        wmask_in  = 4'h0;
        trap_in   = 1'b0;
        dmem_resp = 1'b0;
        hold_off  = 1'b0;
    endtask

    task automatic run_op(input op_t o);
        logic        ism;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        logic [31:0] exp_alu;
        reg_bundle_t exp_regs;
        rm = 4'h0;
        wm = 4'h0;
        if (o.kind == 1) rm = lane_mask(o.f3, o.shift);
        if (o.kind == 2) wm = lane_mask(o.f3, o.shift);
        if (o.kind == 3) rm = 4'hF;
        ism     = (o.kind == 1) || (o.kind == 2);
        exp_wd  = o.wdata << {o.shift, 3'b000};
        exp_ld  = (o.kind == 1) ? ref_load(o.f3, o.shift, o.rdata) : 32'h0;
        exp_alu = {o.addr[31:2], o.shift};
        exp_regs = {$urandom(), $urandom(), $urandom()};

        @(negedge clk);
        pc_mem               = o.pc;
        ctrl_mem.opcode      = 7'($urandom());
        ctrl_mem.funct3      = o.f3;
        ctrl_mem.load_regfile = (o.kind == 1);
        regs_mem             = exp_regs;
        br_en_mem            = 1'b1;
        addr_aligned         = {o.addr[31:2], 2'b00};
        alu_res_in           = exp_alu;
        bit_shift            = o.shift;
        rmask_in             = rm;
        wmask_in             = wm;
        trap_in              = (o.kind == 3);
        write_data_in        = o.wdata;
        dmem_resp            = 1'b0;
        hold_off             = ism && (o.hold > 0);

        if (!ism) begin
            #1;
            check("nomem_stall", 32'(mem_stall), 32'h0);
            check("nomem_rd_wr", {30'h0, dmem_read, dmem_write}, 32'h0);
        end else begin
            for (int k = 0; k <= o.lat; k++) begin
                if (k > 0) @(negedge clk);
                dmem_resp  = (k == o.lat);
                dmem_rdata = (k == o.lat) ? o.rdata : $urandom();
                #1;
                check("stall", 32'(mem_stall), 32'(k < o.lat));
                check("dmem_read", 32'(dmem_read), 32'(o.kind == 1));
                check("dmem_write", 32'(dmem_write), 32'(o.kind == 2));
                check("wb_held_pc", pc_wb, BUBBLE_PC);
                if (k == 0) begin
                    check("byte_en", 32'(dmem_byte_enable), 32'(o.kind == 1 ? rm : wm));
                    check("dmem_addr", dmem_address, {o.addr[31:2], 2'b00});
                    if (o.kind == 2) check("dmem_wdata", dmem_wdata, exp_wd);
                end
            end
            for (int h = 1; h <= o.hold; h++) begin
                @(negedge clk);
                dmem_resp  = 1'b0;
                dmem_rdata = $urandom();
                if (h == o.hold) hold_off = 1'b0;
                #1;
                check("hold_stall", 32'(mem_stall), 32'h0);
                check("hold_noreq", {30'h0, dmem_read, dmem_write}, 32'h0);
                check("hold_pc", pc_wb, BUBBLE_PC);
            end
        end

        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = $urandom();
        #1;
        check("pc_wb", pc_wb, o.pc);
        check("load_data_wb", load_data_wb, exp_ld);
        check("trap_wb", 32'(trap_wb), 32'(o.kind == 3));
        check("masks_wb", {24'h0, rmask_wb, wmask_wb}, {24'h0, rm, wm});
        check("mem_wdata_wb", mem_wdata_wb, exp_wd);
        check("alu_res_wb", alu_res_wb, exp_alu);
        check("regs_wb_rd", 32'(regs_wb.rs2_rdata), 32'(exp_regs.rs2_rdata));
        check("ctrl_wb_f3", 32'(ctrl_wb.funct3), 32'(o.f3));
        set_bubble();
    endtask

    function automatic op_t mk(input int kind, input logic [2:0] f3, input logic [1:0] sh,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input int lat, input int hold);
        op_t o;
        o.kind  = kind;
        o.f3    = f3;
        o.shift = sh;
        o.pc    = 32'h0000_1000 + 32'($urandom_range(0, 255) * 4);
        o.addr  = $urandom();
        o.wdata = wd;
        o.rdata = rd;
        o.lat   = lat;
        o.hold  = hold;
        return o;
    endfunction

    initial begin
        op_t o;
        logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst           = 1'b1;
        hold_off      = 1'b0;
        pc_mem        = 32'h0;
        ctrl_mem      = '0;
        regs_mem      = '0;
        br_en_mem     = 1'b0;
        addr_aligned  = 32'h0;
        alu_res_in    = 32'h0;
        bit_shift     = 2'b00;
        wmask_in      = 4'h0;
        rmask_in      = 4'h0;
        trap_in       = 1'b0;
        write_data_in = 32'h0;
        dmem_rdata    = 32'h0;
        dmem_resp     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc_wb", pc_wb, 32'h0);
        check("rst_load_data", load_data_wb, 32'h0);
        check("rst_stall", 32'(mem_stall), 32'h0);
        rst = 1'b0;
        set_bubble();

        // Directed cases
        run_op(mk(1, 3'b000, 2'd3, 32'h0, 32'h80FF1234, 3, 0));   // lb -> FFFFFF80
        run_op(mk(1, 3'b101, 2'd2, 32'h0, 32'h80FF1234, 1, 0));   // lhu -> 000080FF
        run_op(mk(1, 3'b001, 2'd2, 32'h0, 32'h80FF1234, 1, 0));   // lh -> FFFF80FF
        run_op(mk(2, 3'b000, 2'd1, 32'h000000AB, 32'h0, 1, 0));   // sb -> 0000AB00
        run_op(mk(1, 3'b010, 2'd0, 32'h0, 32'hDEADBEEF, 1, 2));   // lw through HOLD
        run_op(mk(3, 3'b010, 2'd0, 32'h0, 32'h0, 1, 0));          // trap
        run_op(mk(0, 3'b000, 2'd0, 32'h0, 32'h0, 1, 0));          // non-memory

        // Reset while BUSY
        o = mk(1, 3'b010, 2'd0, 32'h0, 32'h12345678, 5, 0);
        run_op(mk(2, 3'b010, 2'd0, 32'hCAFEF00D, 32'h0, 2, 0));
        @(negedge clk);
        pc_mem       = o.pc;
        addr_aligned = {o.addr[31:2], 2'b00} | 32'h4;
        rmask_in     = 4'hF;
        ctrl_mem.funct3 = 3'b010;
        @(negedge clk);
        #1;
        check("busy_read", 32'(dmem_read), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_drop_read", 32'(dmem_read), 32'h0);
        @(negedge clk);
        #1;
        check("rstbusy_read", 32'(dmem_read), 32'h0);
        check("rstbusy_pc", pc_wb, 32'h0);
        check("rstbusy_addr", mem_addr_wb, 32'h0);
        check("rstbusy_wdata", mem_wdata_wb, 32'h0);
        rst = 1'b0;
        set_bubble();
        #1;
        check("post_rst_idle", 32'(mem_stall), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [2:0] f3;
            logic [1:0] sh;
            kind = int'($urandom_range(0, 3));
            if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else f3 = lf3[$urandom_range(0, 4)];
            case (f3[1:0])
                2'b00:   sh = 2'($urandom_range(0, 3));
                2'b01:   sh = 2'($urandom_range(0, 1) * 2);
                default: sh = 2'd0;
            endcase
            if (kind == 0 || kind == 3) f3 = 3'b010;
            if (kind == 0 || kind == 3) sh = 2'd0;
            run_op(mk(kind, f3, sh, $urandom(), $urandom(),
                      int'($urandom_range(1, 4)),
                      ($urandom_range(0, 3) == 0 && (kind == 1 || kind == 2))
                          ? int'($urandom_range(1, 3)) : 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
